// File: rtl/demux_1x4_mux2_tree_if.sv
// Bus bundle for the registered 1-to-4 demux.
// master drives en/i/s; slave returns y (4 lanes) and y_valid.
interface demux_1x4_mux2_tree_if #(
    parameter int DATA_W = 1
);
    logic                  en;
    logic [DATA_W-1:0]     i;
    logic [1:0]            s;
    logic [4*DATA_W-1:0]   y;
    logic                  y_valid;

    modport master (
        output en, i, s,
        input  y, y_valid
    );

    modport slave (
        input  en, i, s,
        output y, y_valid
    );
endinterface

// File: rtl/demux_1x4_mux2_tree.sv
// Registered 1-to-4 demux built from a two-level tree of 2:1 mux cells.
// Ports: clk, rst (sync, active-high), bus (slave: en, i, s -> y, y_valid).
module mux2_cell #(
    parameter int W = 1
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

module demux_1x4_mux2_tree #(
    parameter int DATA_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1x4_mux2_tree_if.slave bus
);
    logic [DATA_W-1:0]   zero;
    logic [DATA_W-1:0]   din;
    logic [1:0]          sel;
    logic [DATA_W-1:0]   pair_hi;
    logic [DATA_W-1:0]   pair_lo;
    logic [DATA_W-1:0]   lane0;
    logic [DATA_W-1:0]   lane1;
    logic [DATA_W-1:0]   lane2;
    logic [DATA_W-1:0]   lane3;
    logic [4*DATA_W-1:0] core;
    logic [4*DATA_W-1:0] y_q;
    logic                valid_q;

    assign zero = '0;
    assign din  = bus.i;
    assign sel  = bus.s;

    // Level 1: s[1] steers the data into the upper (2/3) or lower (0/1) pair.
    mux2_cell #(.W(DATA_W)) u_l1_hi (
        .d0(zero), .d1(din), .sel(sel[1]), .y(pair_hi)
    );
    mux2_cell #(.W(DATA_W)) u_l1_lo (
        .d0(din), .d1(zero), .sel(sel[1]), .y(pair_lo)
    );

    // Level 2: s[0] picks the lane within each pair.
    mux2_cell #(.W(DATA_W)) u_l2_0 (
        .d0(pair_lo), .d1(zero), .sel(sel[0]), .y(lane0)
    );
    mux2_cell #(.W(DATA_W)) u_l2_1 (
        .d0(zero), .d1(pair_lo), .sel(sel[0]), .y(lane1)
    );
    mux2_cell #(.W(DATA_W)) u_l2_2 (
        .d0(pair_hi), .d1(zero), .sel(sel[0]), .y(lane2)
    );
    mux2_cell #(.W(DATA_W)) u_l2_3 (
        .d0(zero), .d1(pair_hi), .sel(sel[0]), .y(lane3)
    );

    assign core = {lane3, lane2, lane1, lane0};

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            y_q     <= core;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = valid_q;
endmodule

// File: tb/tb_demux_1x4_mux2_tree.sv
// Scoreboard bench for demux_1x4_mux2_tree at DATA_W = 1 and DATA_W = 8.
// Driver pushes hand-computed results; per-DUT monitors pop and compare.
module tb_demux_1x4_mux2_tree;
    logic clk;
    logic rst;

    typedef struct {
        logic        rst;
        logic        en;
        logic [7:0]  i;
        logic [1:0]  s;
        logic [31:0] y;
        logic        v;
    } vec_t;

    vec_t nvec[$];
    vec_t wvec[$];
    logic [32:0] nq[$];
    logic [32:0] wq[$];

    int checks;
    int failures;

    demux_1x4_mux2_tree_if #(.DATA_W(1)) nbus ();
    demux_1x4_mux2_tree_if #(.DATA_W(8)) wbus ();

    demux_1x4_mux2_tree #(.DATA_W(1)) u_narrow (
        .clk(clk),
        .rst(rst),
        .bus(nbus)
    );

    demux_1x4_mux2_tree #(.DATA_W(8)) u_wide (
        .clk(clk),
        .rst(rst),
        .bus(wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addv(
        output vec_t v,
        input logic r, input logic e, input logic [7:0] d,
        input logic [1:0] sl, input logic [31:0] ey, input logic ev
    );
        v.rst = r; v.en = e; v.i = d; v.s = sl; v.y = ey; v.v = ev;
    endtask

    // Narrow monitor: y is 4 bits wide.
    always @(posedge clk) begin
        logic [32:0] exp_e;
        #1;
        if (nq.size() > 0) begin
            exp_e = nq.pop_front();
            checks++;
            if (nbus.y !== exp_e[3:0] || nbus.y_valid !== exp_e[32]) begin
                failures++;
                $display("FAIL narrow y=%h v=%b expected y=%h v=%b",
                         nbus.y, nbus.y_valid, exp_e[3:0], exp_e[32]);
            end
        end
    end

    // Wide monitor: y is 32 bits wide.
    always @(posedge clk) begin
        logic [32:0] exp_e;
        #1;
        if (wq.size() > 0) begin
            exp_e = wq.pop_front();
            checks++;
            if (wbus.y !== exp_e[31:0] || wbus.y_valid !== exp_e[32]) begin
                failures++;
                $display("FAIL wide y=%h v=%b expected y=%h v=%b",
                         wbus.y, wbus.y_valid, exp_e[31:0], exp_e[32]);
            end
        end
    end

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        nbus.en  = 1'b0; nbus.i = '0; nbus.s = '0;
        wbus.en  = 1'b0; wbus.i = '0; wbus.s = '0;

        // rst, en, i, s, expected y, expected y_valid
        addv(v, 1, 1, 8'h01, 2'd3, 32'h0, 0); nvec.push_back(v);
        addv(v, 1, 1, 8'h01, 2'd3, 32'h0, 0); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd0, 32'h1, 1); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd1, 32'h2, 1); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd2, 32'h4, 1); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd3, 32'h8, 1); nvec.push_back(v);
        addv(v, 0, 1, 8'h00, 2'd2, 32'h0, 1); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd1, 32'h2, 1); nvec.push_back(v);
        addv(v, 0, 0, 8'h01, 2'd3, 32'h2, 0); nvec.push_back(v);
        addv(v, 0, 0, 8'h01, 2'd3, 32'h2, 0); nvec.push_back(v);
        addv(v, 0, 0, 8'h01, 2'd3, 32'h2, 0); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd2, 32'h4, 1); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd3, 32'h8, 1); nvec.push_back(v);
        addv(v, 1, 1, 8'h01, 2'd3, 32'h0, 0); nvec.push_back(v);
        addv(v, 0, 1, 8'h01, 2'd0, 32'h1, 1); nvec.push_back(v);
        addv(v, 0, 0, 8'h00, 2'd2, 32'h1, 0); nvec.push_back(v);

        addv(v, 1, 1, 8'hFF, 2'd3, 32'h0, 0);         wvec.push_back(v);
        addv(v, 0, 1, 8'hA5, 2'd2, 32'h00A5_0000, 1); wvec.push_back(v);
        addv(v, 0, 1, 8'hA5, 2'd3, 32'hA500_0000, 1); wvec.push_back(v);
        addv(v, 0, 1, 8'h3C, 2'd0, 32'h0000_003C, 1); wvec.push_back(v);
        addv(v, 0, 1, 8'h81, 2'd1, 32'h0000_8100, 1); wvec.push_back(v);
        addv(v, 0, 0, 8'hFF, 2'd2, 32'h0000_8100, 0); wvec.push_back(v);
        addv(v, 0, 1, 8'h00, 2'd3, 32'h0, 1);         wvec.push_back(v);

        foreach (nvec[k]) begin
            @(negedge clk);
            rst     = nvec[k].rst;
            nbus.en = nvec[k].en;
            nbus.i  = nvec[k].i[0];
            nbus.s  = nvec[k].s;
            nq.push_back({nvec[k].v, nvec[k].y});
        end
        @(negedge clk);
        nbus.en = 1'b0;

        foreach (wvec[k]) begin
            @(negedge clk);
            rst     = wvec[k].rst;
            wbus.en = wvec[k].en;
            wbus.i  = wvec[k].i;
            wbus.s  = wvec[k].s;
            wq.push_back({wvec[k].v, wvec[k].y});
        end
        @(negedge clk);
        wbus.en = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (nq.size() != 0 || wq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0",
                     nq.size() + wq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_1x4_mux2_tree.md
Name: demux_1x4_mux2_tree

Overview:
- 1-to-4 demultiplexer. Routes a DATA_W-bit input to one of four output lanes selected by a 2-bit select; the other three lanes are driven to zero.
- Selection logic is built structurally from 2:1 multiplexer cells arranged as a two-level tree.
- A registered output stage gives one-cycle latency, so the block drops into synchronous datapaths as a lane/steering element.

Parameters:
- DATA_W, 1, width of the data input and of each output lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; when high, the demux result is registered this cycle.
- i  input  DATA_W  data input.
- s  input  2  lane select (0..3).
- y  output  4*DATA_W  output lanes; lane k occupies bits [k*DATA_W +: DATA_W].
- y_valid  output  1  high for the cycle following an enabled capture.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Combinational core:
  - lane k = i when s == k, else all-zero.
  - Each lane bit comes from a 2:1 mux cell (data = i, other leg = 0).
  - Level 1 splits on s[1]: upper pair is lanes 2/3, lower pair is lanes 0/1.
  - Level 2 splits on s[0] within each pair.
  - A behavioural case statement is not acceptable.
- Exactly one lane can be non-zero. With i = 0, all lanes are zero regardless of s.
- Register stage, evaluated on the rising edge of clk in this priority order:
  - rst = 1: y <= 0, y_valid <= 0. rst takes priority over en.
  - else en = 1: y <= core result, y_valid <= 1.
  - else: y holds its previous value, y_valid <= 0.
- Latency: a change on i/s with en = 1 appears on y after exactly one clk edge.
- Back-to-back captures: y_valid stays high continuously, and y updates every cycle.
- Reset mid-stream: the output clears on the reset edge. The first capture after rst deasserts produces a result on the following edge.
- s and i are sampled only when en = 1. Changes while en = 0 have no effect on y.
- No X propagation from s: all four s codes are defined. Any X on s is a stimulus error and is not handled specially.
- No combinational path from inputs to outputs.
- Power-on state before the first reset is undefined. The bench must reset first.

Test Plan:
- Reset: assert rst for 2 cycles with en = 1, i = 1, s = 3 -> y = 4'b0000, y_valid = 0 on every reset cycle.
- Lane sweep (DATA_W = 1): en = 1, i = 1, s = 0, 1, 2, 3 on consecutive cycles -> one cycle later y = 1, 2, 4, 8 in turn; y_valid = 1 throughout.
- Zero data: en = 1, i = 0, s = 2 -> y = 0 next cycle, y_valid = 1.
- Hold: capture i = 1, s = 1 (y = 2), then en = 0 with s = 3 for 3 cycles -> y stays 2, y_valid = 0.
- Wide data (DATA_W = 8): i = 8'hA5, s = 2 -> y = 32'h00A5_0000 next cycle. Then s = 3 -> y = 32'hA500_0000.
- Reset priority mid-operation: streaming captures, assert rst together with en = 1 -> y = 0 and y_valid = 0 on that edge. Release rst with i = 1, s = 0 -> y = 1 one cycle later.
